mem_bus_sequencer: RTL
======================

MEM_BUS_SEQUENCER -- requirements
Module: mem_bus_sequencer

Interface
REQ-001 Parameter DataWidth, default 32, SHALL set the data path width.
REQ-002 Parameter AddrWidth, default 24, SHALL set the memory address width.
REQ-003 Parameter TimeoutLimit, default 16, SHALL set the maximum number of WAIT cycles; a 5-bit counter SHALL hold it.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port list, one per line (name, direction, width, meaning):
- clock  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- Start  input  1  request a memory transaction; sampled in IDLE only
- Read_Write  input  1  1 = write, 0 = read; captured with Start
- Mux_Out  input  DataWidth  output of the address/data select mux; {8'b0, addr} when A_Select=0, data when 1
- Mem_Ready  input  1  memory completion strobe
- Mem_Data_In  input  DataWidth  memory read data
- A_Select  output  1  drives the mux select
- Mem_Addr  output  AddrWidth  registered memory address
- Mem_Data_Out  output  DataWidth  registered write data
- Mem_Req  output  1  memory request
- Mem_WE  output  1  write enable; qualified by Mem_Req
- Rd_Data  output  DataWidth  captured read data
- Busy  output  1  high in any state other than IDLE
- Done  output  1  one-cycle completion pulse
- Timeout_Err  output  1  sticky timeout flag

Function
REQ-006 The FSM SHALL have states IDLE, ADDR, DATA, WAIT and DONE; outputs SHALL decode from the state register only (Moore).
REQ-007 IDLE: if Start=1, the block SHALL capture Read_Write into a write flag, clear the WAIT counter and Timeout_Err, and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-008 ADDR: A_Select=0; Mem_Addr SHALL load Mux_Out[AddrWidth-1:0] at the end of the cycle and Mux_Out[31:24] SHALL be ignored; next state SHALL be DATA if the write flag is set, else WAIT.
REQ-009 DATA: A_Select=1; Mem_Data_Out SHALL load Mux_Out at the end of the cycle; next state SHALL be WAIT.
REQ-010 WAIT: Mem_Req=1 and Mem_WE=write flag; the counter SHALL increment once per cycle spent in WAIT.
REQ-011 In WAIT, if Mem_Ready=1 then Rd_Data SHALL load Mem_Data_In on a read (unchanged on a write) and the next state SHALL be DONE.
REQ-012 In WAIT, if Mem_Ready=0 and counter = TimeoutLimit-1, Timeout_Err SHALL set and the next state SHALL be DONE; Rd_Data SHALL remain unchanged.
REQ-013 If Mem_Ready=1 in the timeout cycle, Mem_Ready SHALL win and Timeout_Err SHALL stay 0.
REQ-014 DONE: Done=1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-015 Start SHALL be ignored outside IDLE; back-to-back transactions SHALL be spaced by at least one IDLE cycle.
REQ-016 Mem_Ready outside WAIT SHALL be ignored.
REQ-017 Read latency with Mem_Ready already high: Start sampled in cycle T; ADDR in T+1; WAIT/Mem_Req in T+2; Done in T+3.
REQ-018 Write latency with Mem_Ready already high: Done in T+4.
REQ-019 A_Select SHALL be 0 in every state except DATA.
REQ-020 Timeout_Err SHALL persist through DONE and IDLE until the next accepted Start or reset.

Reset
REQ-021 With reset=1 at a clock edge, the state SHALL become IDLE and the counter 0.
REQ-022 Reset SHALL clear the write flag, Mem_Addr, Mem_Data_Out, Rd_Data and Timeout_Err to 0.
REQ-023 After reset, Mem_Req, Mem_WE, A_Select, Busy and Done SHALL all be 0.
REQ-024 Reset asserted mid-transaction SHALL abort it: Mem_Req low from the next cycle, no Done pulse, and Start ignored while reset=1.

Verification
REQ-025 Read, no wait: Start=1, Read_Write=0, Mux_Out=32'h00ABCDEF in ADDR, Mem_Ready=1, Mem_Data_In=32'h12345678 -> Mem_Addr=24'hABCDEF, Mem_WE=0, Rd_Data=32'h12345678, Done in T+3.
REQ-026 Write, 3 wait cycles: Read_Write=1, Mux_Out=32'hFF001000 in ADDR then 32'hDEADBEEF in DATA, Mem_Ready after 3 WAIT cycles -> Mem_Addr=24'h001000, Mem_Data_Out=32'hDEADBEEF, A_Select=1 only in DATA, Mem_WE=1, Done in T+7.
REQ-027 Timeout: read with Mem_Ready held 0 -> 16 WAIT cycles, Timeout_Err=1, Done once, Rd_Data unchanged; Timeout_Err cleared on the next Start.
REQ-028 Ready in the timeout cycle: Mem_Ready=1 in the 16th WAIT cycle -> Timeout_Err=0, Rd_Data updated.
REQ-029 Reset in WAIT: reset=1 in the second WAIT cycle -> next cycle IDLE, all outputs 0, no Done.
REQ-030 Start held high through a whole transaction -> exactly one transaction per IDLE acceptance; Start during ADDR/DATA/WAIT/DONE has no effect.

Source files
------------

// File: rtl/mem_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_sequencer
// Description : Moore FSM sequencing address/data capture through an external
//               mux and a request/ready memory handshake with a WAIT timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_sequencer #(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 24,
  parameter int TimeoutLimit = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Start,
  input  logic                 Read_Write,
  input  logic [DataWidth-1:0] Mux_Out,
  input  logic                 Mem_Ready,
  input  logic [DataWidth-1:0] Mem_Data_In,
  output logic                 A_Select,
  output logic [AddrWidth-1:0] Mem_Addr,
  output logic [DataWidth-1:0] Mem_Data_Out,
  output logic                 Mem_Req,
  output logic                 Mem_WE,
  output logic [DataWidth-1:0] Rd_Data,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Timeout_Err
);

  localparam logic [4:0] c_cnt_last = 5'(TimeoutLimit - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_write;
  logic [4:0]           r_cnt;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_timeout;
  logic                 w_expire;

  // Ready in the final WAIT cycle takes precedence over the timeout.
  assign w_expire = !Mem_Ready && (r_cnt == c_cnt_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_write   <= 1'b0;
      r_cnt     <= 5'd0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_write   <= Read_Write;
            r_cnt     <= 5'd0;
            r_timeout <= 1'b0;
          end
        end
        S_ADDR: r_addr  <= Mux_Out[AddrWidth-1:0];
        S_DATA: r_wdata <= Mux_Out;
        S_WAIT: begin
          r_cnt <= r_cnt + 5'd1;
          if (Mem_Ready) begin
            if (!r_write) begin
              r_rdata <= Mem_Data_In;
            end
          end else if (w_expire) begin
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = Start ? S_ADDR : S_IDLE;
      S_ADDR:  w_next = r_write ? S_DATA : S_WAIT;
      S_DATA:  w_next = S_WAIT;
      S_WAIT:  w_next = (Mem_Ready || w_expire) ? S_DONE : S_WAIT;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign A_Select     = (r_state == S_DATA);
  assign Mem_Req      = (r_state == S_WAIT);
  assign Mem_WE       = (r_state == S_WAIT) && r_write;
  assign Busy         = (r_state != S_IDLE);
  assign Done         = (r_state == S_DONE);
  assign Mem_Addr     = r_addr;
  assign Mem_Data_Out = r_wdata;
  assign Rd_Data      = r_rdata;
  assign Timeout_Err  = r_timeout;

endmodule
`default_nettype wire
